// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the uart_rx_fifo receive buffer.
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN (see uart_rx_fifo.sv).
package uart_rx_fifo_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEN_MIN = 5;
  localparam int unsigned LEN_MAX = 8;

  // Mask that keeps only the active data bits; illegal lengths pass all bits through.
  function automatic logic [DATA_W-1:0] len_mask(input logic [3:0] length);
    logic [DATA_W-1:0] mask;
    mask = '1;
    if (length >= 4'(LEN_MIN) && length < 4'(LEN_MAX)) begin
      mask = mask >> (4'(LEN_MAX) - length);
    end
    return mask;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host read port of the receive FIFO: first-word-fall-through valid/ready.
interface uart_rx_fifo_if;

  logic [uart_rx_fifo_pkg::DATA_W-1:0] rd_data;
  logic                                rd_err;
  logic                                rd_valid;
  logic                                rd_ready;

  // FIFO side drives data/valid, host side drives ready.
  modport master (
    output rd_data,
    output rd_err,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_err,
    input  rd_valid,
    output rd_ready
  );

endinterface

// File: rtl/uart_rx_fifo_sync_pulse.sv
// Two-flop synchronizer followed by a rising-edge detector producing a one-cycle pulse.
// All flops reset to 1 so an input already high at reset release is not seen as an edge,
// and an input low at release only produces a falling transition.
module uart_sync_pulse (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronizer chain and previous-sample flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind uart_rx: captures each completed frame, masks it to the word
// length, and queues it in a FWFT FIFO served over a valid/ready read port.
// Build option: define UART_RX_FIFO_ERR_TAG_EN to store errored bytes with an error tag
// (rd_err); otherwise errored bytes are discarded and counted in drop_cnt.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_en,
  output logic                     rx_start,
  input  logic                     rx_done,
  input  logic                     rx_err,
  input  logic [DATA_W-1:0]        rx_out,
  input  logic [3:0]               length,
  input  logic                     flush,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  uart_rx_fifo_if.master           rd
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] CountMax = (AW + 1)'(DEPTH);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int unsigned EntryW = DATA_W + 1;
`else
  localparam int unsigned EntryW = DATA_W;
`endif

  logic              done_pulse;
  logic [1:0]        err_sync_q;
  logic              err_sync;
  logic              err_seen_q, err_seen_d;
  logic              entry_err;
  logic [DATA_W-1:0] data_masked;
  logic [EntryW-1:0] wr_entry;
  logic              push_data;
  logic              wr_en;
  logic              pop;
  logic              empty;
  logic              ovf_set;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              rx_start_q;
  logic [EntryW-1:0] mem [DEPTH];

  uart_sync_pulse u_done_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (rx_done),
    .pulse (done_pulse)
  );

  // Plain two-flop synchronizer for the error status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sync_q <= 2'b00;
    end else begin
      err_sync_q <= {err_sync_q[0], rx_err};
    end
  end

  assign err_sync  = err_sync_q[1];
  assign entry_err = err_seen_q | err_sync;

  // Remember an error seen before the frame completes; the frame's push consumes it.
  always_comb begin
    err_seen_d = err_seen_q;
    if (done_pulse) begin
      err_seen_d = 1'b0;
    end else if (err_sync) begin
      err_seen_d = 1'b1;
    end
  end

  assign data_masked = rx_out & len_mask(length);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign wr_entry  = {entry_err, data_masked};
  assign push_data = done_pulse;
`else
  assign wr_entry  = data_masked;
  assign push_data = done_pulse & ~entry_err;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == CountMax);
  assign pop   = rd.rd_ready & ~empty;

  // Pointer, occupancy and overflow next-state; flush overrides any push or pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    ovf_set = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      wr_en   = push_data & (~full | pop);
      ovf_set = push_data & full & ~pop;
      if (wr_en) wptr_d = wptr_q + AW'(1);
      if (pop)   rptr_d = rptr_q + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
    overflow_d = ovf_set | (overflow_q & ~ovf_clr);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_seen_q <= 1'b0;
      rx_start_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_seen_q <= err_seen_d;
      rx_start_q <= rx_en & ~full;
    end
  end

  // Storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= wr_entry;
    end
  end

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign drop_cnt  = 8'd0;
  assign rd.rd_err = mem[rptr_q][DATA_W] & ~empty;
`else
  logic [7:0] drop_q, drop_d;

  // Saturating count of errored bytes that were discarded instead of stored.
  always_comb begin
    drop_d = drop_q;
    if (done_pulse && entry_err && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt  = drop_q;
  assign rd.rd_err = 1'b0;
`endif

  assign rd.rd_data  = mem[rptr_q][DATA_W-1:0];
  assign rd.rd_valid = ~empty;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign rx_start    = rx_start_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       rx_en   = 1'b0;
  logic       rx_done = 1'b0;
  logic       rx_err  = 1'b0;
  logic       flush   = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rx_out  = 8'h00;
  logic [3:0] length  = 4'd8;
  logic       rx_start;
  logic       full;
  logic       overflow;
  logic [4:0] count;
  logic [7:0] drop_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  uart_rx_fifo_if rd_if ();

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_en    (rx_en),
    .rx_start (rx_start),
    .rx_done  (rx_done),
    .rx_err   (rx_err),
    .rx_out   (rx_out),
    .length   (length),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .rd       (rd_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise rx_done with data; return #1 after the third clock edge, when the entry is written.
  task automatic send_frame(input logic [7:0] data, input logic err, input bit chk_lat);
    @(negedge clk);
    rx_out  = data;
    rx_err  = err;
    rx_done = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    @(posedge clk);
    #1;
    if (chk_lat) check("lat_valid_e2", 32'(rd_if.rd_valid), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic release_done();
    @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] data, input logic err);
    send_frame(data, err, 1'b0);
    release_done();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp, input logic exp_err);
    @(negedge clk);
    check({tag, "_valid"}, 32'(rd_if.rd_valid), 32'h1);
    check({tag, "_data"}, 32'(rd_if.rd_data), 32'(exp));
    check({tag, "_err"}, 32'(rd_if.rd_err), 32'(exp_err));
    rd_if.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_start"}, 32'(rx_start), 32'h0);
    check({tag, "_rd_valid"}, 32'(rd_if.rd_valid), 32'h0);
    check({tag, "_count"}, 32'(count), 32'h0);
    check({tag, "_full"}, 32'(full), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'h0);
    check({tag, "_rd_err"}, 32'(rd_if.rd_err), 32'h0);
  endtask

  initial begin
    logic [7:0] t1_vals [4];
    t1_vals[0] = 8'hA5;
    t1_vals[1] = 8'h3C;
    t1_vals[2] = 8'hFF;
    t1_vals[3] = 8'h00;
    rd_if.rd_ready = 1'b0;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst   = 1'b1;
    rx_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rx_start_en", 32'(rx_start), 32'h1);

    // T1: in-order delivery, 3-cycle latency
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_frame(t1_vals[i], 1'b0, 1'b1);
      check("t1_valid_e3", 32'(rd_if.rd_valid), 32'h1);
      check("t1_data", 32'(rd_if.rd_data), 32'(t1_vals[i]));
      release_done();
    end
    check("t1_count_end", 32'(count), 32'h0);

    // T2: word-length masking
    length = 4'd5;
    send_frame(8'hFF, 1'b0, 1'b0);
    check("t2_len5", 32'(rd_if.rd_data), 32'h1F);
    release_done();
    length = 4'd6;
    send_frame(8'hFF, 1'b0, 1'b0);
    check("t2_len6", 32'(rd_if.rd_data), 32'h3F);
    release_done();
    length = 4'd7;
    send_frame(8'hAA, 1'b0, 1'b0);
    check("t2_len7", 32'(rd_if.rd_data), 32'h2A);
    release_done();
    length = 4'd12;
    send_frame(8'h81, 1'b0, 1'b0);
    check("t2_len12", 32'(rd_if.rd_data), 32'h81);
    release_done();
    length = 4'd8;
    rd_if.rd_ready = 1'b0;

    // T3: fill, overflow, clear, drain
    for (int i = 0; i < 16; i++) frame(8'(i * 37 + 5), 1'b0);
    check("t3_full", 32'(full), 32'h1);
    check("t3_count16", 32'(count), 32'd16);
    check("t3_rx_start", 32'(rx_start), 32'h0);
    check("t3_ovf_before", 32'(overflow), 32'h0);
    frame(8'h77, 1'b0);
    check("t3_overflow", 32'(overflow), 32'h1);
    check("t3_count_ovf", 32'(count), 32'd16);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) pop_check("t3_pop", 8'(i * 37 + 5), 1'b0);
    check("t3_count_end", 32'(count), 32'h0);

    // T4: push and pop on the same edge while full
    for (int i = 0; i < 16; i++) frame(8'(i * 11 + 1), 1'b0);
    @(negedge clk);
    rx_out  = 8'hC3;
    rx_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_if.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_if.rd_ready = 1'b0;
    check("t4_count", 32'(count), 32'd16);
    check("t4_head", 32'(rd_if.rd_data), 32'h0C);
    check("t4_overflow", 32'(overflow), 32'h0);
    release_done();
    for (int i = 1; i < 16; i++) pop_check("t4_pop", 8'(i * 11 + 1), 1'b0);
    pop_check("t4_tail", 8'hC3, 1'b0);
    check("t4_count_end", 32'(count), 32'h0);

    // T5: errored middle frame
    frame(8'h11, 1'b0);
    frame(8'h22, 1'b1);
    frame(8'h33, 1'b0);
`ifdef UART_RX_FIFO_ERR_TAG_EN
    check("t5_count", 32'(count), 32'd3);
    check("t5_drop_cnt", 32'(drop_cnt), 32'h0);
    pop_check("t5_pop0", 8'h11, 1'b0);
    pop_check("t5_pop1", 8'h22, 1'b1);
    pop_check("t5_pop2", 8'h33, 1'b0);
`else
    check("t5_count", 32'(count), 32'd2);
    check("t5_drop_cnt", 32'(drop_cnt), 32'h1);
    pop_check("t5_pop0", 8'h11, 1'b0);
    pop_check("t5_pop1", 8'h33, 1'b0);
`endif
    check("t5_count_end", 32'(count), 32'h0);

    // T6: flush colliding with a push, then async reset mid-frame
    for (int i = 0; i < 5; i++) frame(8'(8'h40 + i), 1'b0);
    check("t6_count5", 32'(count), 32'd5);
    @(negedge clk);
    rx_out  = 8'h99;
    rx_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("t6_flush_count", 32'(count), 32'h0);
    check("t6_flush_valid", 32'(rd_if.rd_valid), 32'h0);
    release_done();
    frame(8'h50, 1'b0);
    frame(8'h51, 1'b0);
    check("t6_count2", 32'(count), 32'd2);
    check("t6_head", 32'(rd_if.rd_data), 32'h50);
    @(negedge clk);
    rx_out  = 8'h66;
    rx_done = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_spurious", 32'(count), 32'h0);
    check("t6_rx_start", 32'(rx_start), 32'h1);
    rx_done = 1'b0;
    release_done();
    frame(8'h5A, 1'b0);
    pop_check("t6_after_rst", 8'h5A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
